mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_pkg.sv | 29 ++
 rtl/mem_bus_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-port memory bus controller.
package mem_bus_pkg;

    localparam int unsigned ADDR_W        = 8;
    localparam int unsigned DATA_W        = 8;
    localparam int unsigned RAM_DEPTH_DEF = 128;
    localparam int unsigned TIMEOUT_DEF   = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Memory-side command held stable for the whole access
    typedef struct packed {
        logic              en;
        logic              read;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned       depth);
        return 32'(addr) < depth;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// Arbitrates an instruction-fetch port and a data port onto one memory bus,
// with a ready timeout and out-of-range address rejection.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
    parameter int unsigned RAM_DEPTH = RAM_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              mem_en,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e            state_q, state_nxt;
    logic              grant_d_q, grant_d_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    mem_cmd_t          cmd_q, cmd_nxt;
    logic              if_ack_nxt, d_ack_nxt, err_nxt;
    logic [DATA_W-1:0] if_data_nxt, d_rdata_nxt;

    logic [ADDR_W-1:0] sel_addr;
    logic              sel_write;
    logic              finish;
    logic              done_err;
    logic [DATA_W-1:0] done_data;

    assign mem_en      = cmd_q.en;
    assign mem_read    = cmd_q.read;
    assign mem_write   = cmd_q.write;
    assign mem_address = cmd_q.addr;
    assign mem_wdata   = cmd_q.wdata;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_d_q <= 1'b0;
            cnt_q     <= '0;
            cmd_q     <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
            if_data   <= '0;
            d_rdata   <= '0;
        end else begin
            state_q   <= state_nxt;
            grant_d_q <= grant_d_nxt;
            cnt_q     <= cnt_nxt;
            cmd_q     <= cmd_nxt;
            if_ack    <= if_ack_nxt;
            d_ack     <= d_ack_nxt;
            err       <= err_nxt;
            if_data   <= if_data_nxt;
            d_rdata   <= d_rdata_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state_q;
        grant_d_nxt = grant_d_q;
        cnt_nxt     = cnt_q;
        cmd_nxt     = cmd_q;
        if_ack_nxt  = 1'b0;
        d_ack_nxt   = 1'b0;
        err_nxt     = 1'b0;
        if_data_nxt = if_data;
        d_rdata_nxt = d_rdata;
        sel_addr    = d_req ? d_addr : if_addr;
        sel_write   = d_req & d_we;
        finish      = 1'b0;
        done_err    = 1'b0;
        done_data   = '0;

        case (state_q)
            ST_IDLE: begin
                if (d_req || if_req) begin
                    grant_d_nxt = d_req;
                    if (addr_in_range(sel_addr, RAM_DEPTH)) begin
                        state_nxt     = ST_ACCESS;
                        cnt_nxt       = '0;
                        cmd_nxt.en    = 1'b1;
                        cmd_nxt.read  = ~sel_write;
                        cmd_nxt.write = sel_write;
                        cmd_nxt.addr  = sel_addr;
                        cmd_nxt.wdata = sel_write ? d_wdata : '0;
                    end else begin
                        finish   = 1'b1;
                        done_err = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                // Ready wins over a timeout landing in the same cycle
                if (mem_ready) begin
                    finish    = 1'b1;
                    done_data = cmd_q.read ? mem_rdata : '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    finish   = 1'b1;
                    done_err = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Completion: drop strobes and acknowledge only the granted port
        if (finish) begin
            state_nxt     = ST_DONE;
            cmd_nxt.en    = 1'b0;
            cmd_nxt.read  = 1'b0;
            cmd_nxt.write = 1'b0;
            err_nxt       = done_err;
            if (grant_d_nxt) begin
                d_ack_nxt   = 1'b1;
                d_rdata_nxt = done_data;
            end else begin
                if_ack_nxt  = 1'b1;
                if_data_nxt = done_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl against a small RAM whose ready rises on
// a programmable enabled edge.
module tb_mem_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       if_req = 1'b0;
    logic [7:0] if_addr = '0;
    logic       if_ack;
    logic [7:0] if_data;
    logic       d_req = 1'b0;
    logic       d_we = 1'b0;
    logic [7:0] d_addr = '0;
    logic [7:0] d_wdata = '0;
    logic       d_ack;
    logic [7:0] d_rdata;
    logic       err;
    logic       mem_en, mem_read, mem_write;
    logic [7:0] mem_address, mem_wdata, mem_rdata;
    logic       mem_ready;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_bus_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .mem_en(mem_en), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // Memory model: ready registered high once cnt >= ready_delay-1 at an enabled edge
    logic [7:0] ram [256];
    int         ready_delay = 2;
    int         mcnt;
    logic       mready_q;

    assign mem_ready = mready_q;
    assign mem_rdata = ram[mem_address];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt     <= 0;
            mready_q <= 1'b0;
        end else if (!mem_en) begin
            mcnt     <= 0;
            mready_q <= 1'b0;
        end else begin
            if (mem_write && mready_q) ram[mem_address] <= mem_wdata;
            mcnt     <= mcnt + 1;
            mready_q <= (mcnt >= ready_delay - 1);
        end
    end

    // mem_en activity monitor
    int en_cycles = 0;
    int low_run = 0;
    int last_gap = 0;
    logic en_seen = 1'b0;

    always @(negedge clk) begin
        if (mem_en) begin
            en_cycles <= en_cycles + 1;
            if (en_seen && low_run > 0) last_gap <= low_run;
            low_run <= 0;
            en_seen <= 1'b1;
        end else begin
            low_run <= low_run + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction; edges counts posedges from request until ack is seen
    task automatic access(input logic is_d, input logic we, input logic [7:0] addr,
                          input logic [7:0] wd, output int edges,
                          output logic [7:0] data, output logic e);
        @(posedge clk); #1;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        edges = 0; data = '0; e = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            edges++;
            if (is_d ? d_ack : if_ack) begin
                data = is_d ? d_rdata : if_data;
                e = err;
                break;
            end
        end
        d_req = 1'b0; if_req = 1'b0;
    endtask

    int         ed, t, td, ti, en_before, early_if, acks;
    logic [7:0] dv, iv;
    logic       ev;

    initial begin
        #2;
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_addr", 32'(mem_address), 32'd0);
        check("rst_rdata", {16'd0, if_data, d_rdata}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Preload through the data port
        access(1'b1, 1'b1, 8'd33, 8'hD0, ed, dv, ev);
        check("wr33_lat", 32'(ed), 32'd4);
        check("wr33_ram", 32'(ram[33]), 32'hD0);

        access(1'b0, 1'b0, 8'd33, 8'h00, ed, dv, ev);
        check("if33_lat", 32'(ed), 32'd4);
        check("if33_data", 32'(dv), 32'hD0);
        check("if33_err", 32'(ev), 32'd0);

        access(1'b1, 1'b1, 8'd40, 8'h5A, ed, dv, ev);
        check("wr40_err", 32'(ev), 32'd0);
        access(1'b1, 1'b0, 8'd40, 8'h00, ed, dv, ev);
        check("rd40_lat", 32'(ed), 32'd4);
        check("rd40_data", 32'(dv), 32'h5A);
        check("rd40_err", 32'(ev), 32'd0);
        check("en_gap_ge1", 32'(last_gap >= 1), 32'd1);

        // Simultaneous requests: data first, fetch 5 cycles after d_ack
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'd40;
        if_req = 1'b1; if_addr = 8'd33;
        t = 0; td = 0; ti = 0; early_if = 0; dv = '0; iv = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            t++;
            if (d_ack) begin
                td = t; dv = d_rdata; d_req = 1'b0;
            end
            if (if_ack) begin
                if (td == 0) early_if = 1;
                ti = t; iv = if_data; if_req = 1'b0;
                break;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        check("arb_d_lat", 32'(td), 32'd4);
        check("arb_if_after_d", 32'(ti - td), 32'd5);
        check("arb_if_early", 32'(early_if), 32'd0);
        check("arb_d_data", 32'(dv), 32'h5A);
        check("arb_if_data", 32'(iv), 32'hD0);

        // Out-of-range data read
        en_before = en_cycles;
        access(1'b1, 1'b0, 8'd200, 8'h00, ed, dv, ev);
        check("oor_lat", 32'(ed), 32'd1);
        check("oor_err", 32'(ev), 32'd1);
        check("oor_data", 32'(dv), 32'h00);
        check("oor_no_en", 32'(en_cycles - en_before), 32'd0);

        // Address boundary on the fetch port
        access(1'b1, 1'b1, 8'd127, 8'h3C, ed, dv, ev);
        access(1'b0, 1'b0, 8'd127, 8'h00, ed, dv, ev);
        check("if127_data", 32'(dv), 32'h3C);
        check("if127_err", 32'(ev), 32'd0);
        access(1'b0, 1'b0, 8'd128, 8'h00, ed, dv, ev);
        check("if128_err", 32'(ev), 32'd1);
        check("if128_data", 32'(dv), 32'h00);

        // Timeout with ready never rising
        ready_delay = 255;
        access(1'b1, 1'b0, 8'd40, 8'h00, ed, dv, ev);
        check("to_lat", 32'(ed), 32'd16);
        check("to_err", 32'(ev), 32'd1);
        check("to_data", 32'(dv), 32'h00);

        // Ready in the final wait cycle still succeeds
        ready_delay = 14;
        access(1'b1, 1'b0, 8'd40, 8'h00, ed, dv, ev);
        check("edge_ok_lat", 32'(ed), 32'd16);
        check("edge_ok_err", 32'(ev), 32'd0);
        check("edge_ok_data", 32'(dv), 32'h5A);

        // Ready one cycle too late times out
        ready_delay = 15;
        access(1'b0, 1'b0, 8'd33, 8'h00, ed, dv, ev);
        check("edge_late_err", 32'(ev), 32'd1);
        check("edge_late_data", 32'(dv), 32'h00);
        ready_delay = 2;

        // Request dropped mid-access still completes
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'd50; d_wdata = 8'h77;
        @(posedge clk); #1;
        d_req = 1'b0;
        t = 1; td = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            t++;
            if (d_ack) begin
                td = t;
                break;
            end
        end
        check("drop_lat", 32'(td), 32'd4);
        access(1'b1, 1'b0, 8'd50, 8'h00, ed, dv, ev);
        check("drop_rd", 32'(dv), 32'h77);

        // Reset in the middle of an access
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'd60; d_wdata = 8'h99;
        @(posedge clk); #1;
        check("mid_en_before", 32'(mem_en), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_en", 32'(mem_en), 32'd0);
        check("mid_rst_wr", 32'(mem_write), 32'd0);
        check("mid_rst_addr", 32'(mem_address), 32'd0);
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (d_ack || if_ack) acks++;
        end
        d_req = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (d_ack || if_ack) acks++;
        end
        check("mid_rst_no_ack", 32'(acks), 32'd0);
        access(1'b0, 1'b0, 8'd33, 8'h00, ed, dv, ev);
        check("post_rst_lat", 32'(ed), 32'd4);
        check("post_rst_data", 32'(dv), 32'hD0);
        check("post_rst_err", 32'(ev), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
